rf_alu_decode_unit: RTL and testbench

- Execute-side datapath slice of the single-cycle RV32 core, sitting between the decoder and write-back.
- Contains a 32x32 integer register file with x0 hardwired to zero.
- Contains a combinational 32-bit ALU whose operation is selected by a 3-bit code, decoded internally to one-hot.
- Contains a standalone 3-to-8 one-hot decoder used by the instruction decoder for funct3.

---
 rtl/rf_alu_decode_unit.sv | 88 ++++++++
 tb/tb_rf_alu_decode_unit.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rf_alu_decode_unit.sv
// Execute-side datapath slice: 32-entry register file (x0 reads zero),
// one-hot selected ALU and a standalone funct3 one-hot decoder.
module rf_alu_decode_unit #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned REG_AW = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rf_wen,
  input  logic [REG_AW-1:0] rf_waddr,
  input  logic [XLEN-1:0]   rf_wdata,
  input  logic [REG_AW-1:0] rf_raddr1,
  output logic [XLEN-1:0]   rf_rdata1,
  input  logic [REG_AW-1:0] rf_raddr2,
  output logic [XLEN-1:0]   rf_rdata2,
  input  logic [XLEN-1:0]   alu_src1,
  input  logic [XLEN-1:0]   alu_src2,
  input  logic [2:0]        alu_op,
  output logic [XLEN-1:0]   alu_result,
  input  logic [2:0]        dec_in,
  output logic [7:0]        dec_out
);

  localparam int unsigned NumRegs = 2 ** REG_AW;
  localparam int unsigned ShW     = $clog2(XLEN);

  // ---------------------------------------------------------------------------
  // Register file
  // ---------------------------------------------------------------------------
  logic [XLEN-1:0] regs_q [NumRegs];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < int'(NumRegs); i++) begin
        regs_q[i] <= '0;
      end
    end else if (rf_wen && (rf_waddr != '0)) begin
      regs_q[rf_waddr] <= rf_wdata;
    end
  end

  // No write-through bypass: reads see the pre-edge contents.
  always_comb begin
    rf_rdata1 = (rf_raddr1 == '0) ? '0 : regs_q[rf_raddr1];
    rf_rdata2 = (rf_raddr2 == '0) ? '0 : regs_q[rf_raddr2];
  end

  // ---------------------------------------------------------------------------
  // ALU: every operation is computed, each gated by its one-hot select bit
  // ---------------------------------------------------------------------------
  logic [7:0]      op_onehot;
  logic [ShW-1:0]  shamt;
  logic [XLEN-1:0] res_add, res_sub, res_and, res_or, res_xor;
  logic [XLEN-1:0] res_sll, res_srl, res_sra;

  always_comb begin
    op_onehot = 8'b1 << alu_op;
    shamt     = alu_src2[ShW-1:0];
    res_add   = alu_src1 + alu_src2;
    res_sub   = alu_src1 - alu_src2;
    res_and   = alu_src1 & alu_src2;
    res_or    = alu_src1 | alu_src2;
    res_xor   = alu_src1 ^ alu_src2;
    res_sll   = alu_src1 << shamt;
    res_srl   = alu_src1 >> shamt;
    res_sra   = $unsigned($signed(alu_src1) >>> shamt);
  end

  always_comb begin
    alu_result = '0;
    alu_result = alu_result | ({XLEN{op_onehot[0]}} & res_add);
    alu_result = alu_result | ({XLEN{op_onehot[1]}} & res_sub);
    alu_result = alu_result | ({XLEN{op_onehot[2]}} & res_and);
    alu_result = alu_result | ({XLEN{op_onehot[3]}} & res_or);
    alu_result = alu_result | ({XLEN{op_onehot[4]}} & res_xor);
    alu_result = alu_result | ({XLEN{op_onehot[5]}} & res_sll);
    alu_result = alu_result | ({XLEN{op_onehot[6]}} & res_srl);
    alu_result = alu_result | ({XLEN{op_onehot[7]}} & res_sra);
  end

  // ---------------------------------------------------------------------------
  // funct3 decoder
  // ---------------------------------------------------------------------------
  always_comb begin
    dec_out = 8'b1 << dec_in;
  end

endmodule

// File: tb/tb_rf_alu_decode_unit.sv
// Scoreboard bench for rf_alu_decode_unit: stimulus queues expected outputs,
// a negedge monitor pops and compares them against the live DUT outputs.
module tb_rf_alu_decode_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        rf_wen;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [4:0]  rf_raddr1;
  logic [31:0] rf_rdata1;
  logic [4:0]  rf_raddr2;
  logic [31:0] rf_rdata2;
  logic [31:0] alu_src1;
  logic [31:0] alu_src2;
  logic [2:0]  alu_op;
  logic [31:0] alu_result;
  logic [2:0]  dec_in;
  logic [7:0]  dec_out;

  rf_alu_decode_unit #(
    .XLEN  (32),
    .REG_AW(5)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .rf_wen    (rf_wen),
    .rf_waddr  (rf_waddr),
    .rf_wdata  (rf_wdata),
    .rf_raddr1 (rf_raddr1),
    .rf_rdata1 (rf_rdata1),
    .rf_raddr2 (rf_raddr2),
    .rf_rdata2 (rf_rdata2),
    .alu_src1  (alu_src1),
    .alu_src2  (alu_src2),
    .alu_op    (alu_op),
    .alu_result(alu_result),
    .dec_in    (dec_in),
    .dec_out   (dec_out)
  );

  always #5 clk = ~clk;

  typedef enum int {SelRd1, SelRd2, SelAlu, SelDec} sel_e;
  typedef struct {
    sel_e        sel;
    logic [31:0] exp;
    string       name;
  } chk_t;

  chk_t        sb[$];
  logic [31:0] model_rf[32];
  int          total = 0;
  int          bad   = 0;

  // Reference ALU from the operation table.
  function automatic logic [31:0] ref_alu(input logic [2:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    int sh;
    sh = int'(b % 32);
    case (op)
      3'd0: return a + b;
      3'd1: return a - b;
      3'd2: return a & b;
      3'd3: return a | b;
      3'd4: return a ^ b;
      3'd5: return a << sh;
      3'd6: return a >> sh;
      default: return $unsigned($signed(a) >>> sh);
    endcase
  endfunction

  function automatic logic [7:0] ref_dec(input logic [2:0] v);
    return 8'(1 << int'(v));
  endfunction

  task automatic push(input sel_e sel, input logic [31:0] exp, input string name);
    chk_t c;
    c.sel  = sel;
    c.exp  = exp;
    c.name = name;
    sb.push_back(c);
  endtask

  // Advance one clock; mirror any write the edge performs into the model.
  task automatic cyc();
    @(posedge clk);
    if (reset && rf_wen && rf_waddr != 5'd0) model_rf[rf_waddr] = rf_wdata;
    #1;
  endtask

  task automatic model_clear();
    for (int i = 0; i < 32; i++) model_rf[i] = 32'd0;
  endtask

  // Monitor: outputs are combinational, so every pending expectation is
  // resolved on the next falling edge.
  initial begin
    forever begin
      @(negedge clk);
      while (sb.size() > 0) begin
        chk_t        c;
        logic [31:0] act;
        c = sb.pop_front();
        case (c.sel)
          SelRd1:  act = rf_rdata1;
          SelRd2:  act = rf_rdata2;
          SelAlu:  act = alu_result;
          default: act = {24'd0, dec_out};
        endcase
        total++;
        if (act !== c.exp) begin
          bad++;
          $display("FAIL %s: got 0x%08h expected 0x%08h", c.name, act, c.exp);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  localparam logic [31:0] A5 = 32'h8000_0001;
  localparam logic [31:0] B5 = 32'h0000_0021;

  initial begin
    logic [31:0] dir_exp[8];
    dir_exp = '{32'h8000_0022, 32'h7FFF_FFE0, 32'h0000_0001, 32'h8000_0021,
                32'h8000_0020, 32'h0000_0002, 32'h4000_0000, 32'hC000_0000};

    reset = 1'b0; rf_wen = 1'b0; rf_waddr = '0; rf_wdata = '0;
    rf_raddr1 = '0; rf_raddr2 = '0; alu_src1 = '0; alu_src2 = '0; alu_op = '0;
    dec_in = '0;
    model_clear();
    #1;

    // Reset state: every address reads zero on both ports.
    for (int i = 0; i < 16; i++) begin
      rf_raddr1 = 5'(2 * i);
      rf_raddr2 = 5'(2 * i + 1);
      push(SelRd1, 32'd0, "reset_rd1");
      push(SelRd2, 32'd0, "reset_rd2");
      cyc();
    end
    reset = 1'b1;

    // x0 writes are discarded.
    rf_wen = 1'b1; rf_waddr = 5'd0; rf_wdata = 32'hDEAD_BEEF;
    cyc();
    rf_wen = 1'b0; rf_raddr1 = 5'd0;
    push(SelRd1, 32'd0, "x0_write");
    cyc();

    // Write then dual read; disabled write leaves x5 alone.
    rf_wen = 1'b1; rf_waddr = 5'd5; rf_wdata = 32'h1234_5678; cyc();
    rf_waddr = 5'd31; rf_wdata = 32'hFFFF_FFFF; cyc();
    rf_wen = 1'b0; rf_waddr = 5'd5; rf_wdata = 32'hCAFE_0000;
    rf_raddr1 = 5'd5; rf_raddr2 = 5'd31;
    push(SelRd1, 32'h1234_5678, "dual_rd1");
    push(SelRd2, 32'hFFFF_FFFF, "dual_rd2");
    cyc();
    push(SelRd1, 32'h1234_5678, "wen0_x5");
    cyc();

    // Read-during-write: old value before the edge, new after.
    rf_wen = 1'b1; rf_waddr = 5'd7; rf_wdata = 32'h11; cyc();
    rf_wdata = 32'h22; rf_raddr1 = 5'd7;
    push(SelRd1, 32'h11, "rdw_before");
    cyc();
    rf_wen = 1'b0;
    push(SelRd1, 32'h22, "rdw_after");
    cyc();

    // Asynchronous reset between edges, then blocked write while held.
    rf_wen = 1'b1; rf_waddr = 5'd3; rf_wdata = 32'hA5; cyc();
    rf_wen = 1'b0; rf_raddr1 = 5'd3; rf_raddr2 = 5'd5;
    push(SelRd1, 32'hA5, "x3_written");
    cyc();
    reset = 1'b0;
    model_clear();
    push(SelRd1, 32'd0, "async_rst_x3");
    push(SelRd2, 32'd0, "async_rst_x5");
    rf_wen = 1'b1; rf_wdata = 32'h55;
    cyc();
    push(SelRd1, 32'd0, "rst_blocks_wr");
    cyc();
    reset = 1'b1;
    cyc();
    rf_wen = 1'b0;
    push(SelRd1, 32'h55, "wr_after_release");
    cyc();

    // Directed ALU vectors.
    alu_src1 = A5; alu_src2 = B5;
    for (int op = 0; op < 8; op++) begin
      alu_op = 3'(op);
      push(SelAlu, dir_exp[op], "alu_dir");
      cyc();
    end
    alu_op = 3'd0; alu_src1 = 32'hFFFF_FFFF; alu_src2 = 32'd1;
    push(SelAlu, 32'd0, "alu_add_wrap");
    cyc();

    // Decoder sweep.
    for (int d = 0; d < 8; d++) begin
      dec_in = 3'(d);
      push(SelDec, 32'(ref_dec(3'(d))), "dec_sweep");
      cyc();
    end

    // Randomized traffic against the model.
    for (int it = 0; it < 400; it++) begin
      rf_wen    = 1'($urandom_range(0, 1));
      rf_waddr  = 5'($urandom_range(0, 31));
      rf_wdata  = $urandom;
      rf_raddr1 = 5'($urandom_range(0, 31));
      rf_raddr2 = ($urandom_range(0, 3) == 0) ? rf_waddr : 5'($urandom_range(0, 31));
      alu_op    = 3'($urandom_range(0, 7));
      alu_src1  = $urandom;
      alu_src2  = $urandom;
      dec_in    = 3'($urandom_range(0, 7));
      push(SelRd1, model_rf[rf_raddr1], "rand_rd1");
      push(SelRd2, model_rf[rf_raddr2], "rand_rd2");
      push(SelAlu, ref_alu(alu_op, alu_src1, alu_src2), "rand_alu");
      push(SelDec, 32'(ref_dec(dec_in)), "rand_dec");
      cyc();
    end
    rf_wen = 1'b0;

    repeat (2) @(negedge clk);
    #1;
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL drain: %0d pending, expected 0", sb.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
